// File: rtl/simon_pkg.sv
// Shared Simon Says definitions: direction codes, player FSM states, default timing.
package simon_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // 10 ms debounce and 1 s response window at 100 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_WINDOW_CYCLES   = 100_000_000;
  localparam int DEF_CNT_W           = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Button vector [0]=up [1]=right [2]=down [3]=left to direction code.
  // Only meaningful for a one-hot input.
  function automatic logic [1:0] encode_dir(input logic [3:0] v);
    logic [1:0] code;
    code = DIR_UP;
    if (v[1]) code = DIR_RIGHT;
    if (v[2]) code = DIR_DOWN;
    if (v[3]) code = DIR_LEFT;
    return code;
  endfunction

endpackage

// File: rtl/simon_debounce.sv
// Two-flop synchroniser plus joint stable-counter debouncer over a WIDTH-bit vector.
// The output follows the synchronised input after DEBOUNCE_CYCLES unchanged, differing cycles.
module simon_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] sync_prev_q, sync_prev_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    eff_cnt;

  always_comb begin
    sync1_d     = din;
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;
    deb_d       = deb_q;
    cnt_d       = '0;
    // A change in the synchronised value makes this cycle the first stable one
    eff_cnt     = (sync2_q != sync_prev_q) ? '0 : cnt_q;
    if (sync2_q != deb_q) begin
      if (eff_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = eff_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
      deb_q       <= '0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/simon_player_input.sv
// Per-player Simon input: debounce buttons, encode a press, judge it against the prompt
// within a bounded window; all result pulses are registered (press-to-result DEBOUNCE_CYCLES+3).
module simon_player_input
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       prompt_valid,
  input  logic [1:0] prompt_dir,
  output logic [1:0] dir_level,
  output logic       resp_valid,
  output logic       resp_hit,
  output logic       resp_miss,
  output logic       resp_timeout,
  output logic       armed
);

  logic [3:0] deb;

  simon_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (btn),
    .dout(deb)
  );

  state_e     state_q, state_d;
  logic [1:0] prompt_q, prompt_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic       blk_q, blk_d;
  logic [3:0] deb_prev_q, deb_prev_d;
  logic [1:0] dir_q, dir_d;
  logic       valid_q, valid_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       tout_q, tout_d;

  logic       press;
  logic       one_hot;
  logic [1:0] code;

  assign press   = |(deb & ~deb_prev_q);
  assign one_hot = $onehot(deb);
  assign code    = encode_dir(deb);

  always_comb begin
    state_d    = state_q;
    prompt_d   = prompt_q;
    win_d      = win_q;
    blk_d      = blk_q;
    deb_prev_d = deb;
    dir_d      = dir_q;
    valid_d    = 1'b0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    tout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (press && one_hot) dir_d = code;
      end
      ARMED: begin
        win_d = win_q + CNT_W'(1);
        if (blk_q && deb == 4'b0000) blk_d = 1'b0;
        // A press beats both window expiry and a superseding prompt
        if (press && !blk_q) begin
          valid_d = 1'b1;
          state_d = RELEASE;
          if (one_hot) begin
            dir_d  = code;
            hit_d  = (code == prompt_q);
            miss_d = (code != prompt_q);
          end else begin
            miss_d = 1'b1;
          end
        end else if (prompt_valid || win_q == CNT_W'(WINDOW_CYCLES - 1)) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (deb == 4'b0000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Buttons still held at prompt time must be released before a press counts
    if (prompt_valid) begin
      state_d  = ARMED;
      prompt_d = prompt_dir;
      win_d    = '0;
      blk_d    = |deb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prompt_q   <= DIR_UP;
      win_q      <= '0;
      blk_q      <= 1'b0;
      deb_prev_q <= '0;
      dir_q      <= DIR_UP;
      valid_q    <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prompt_q   <= prompt_d;
      win_q      <= win_d;
      blk_q      <= blk_d;
      deb_prev_q <= deb_prev_d;
      dir_q      <= dir_d;
      valid_q    <= valid_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      tout_q     <= tout_d;
    end
  end

  assign dir_level    = dir_q;
  assign resp_valid   = valid_q;
  assign resp_hit     = hit_q;
  assign resp_miss    = miss_q;
  assign resp_timeout = tout_q;
  assign armed        = (state_q == ARMED);

endmodule

// File: tb/tb_simon_player_input.sv
// Bench for simon_player_input with short debounce/window; reference model works from button history and deadlines.
module tb_simon_player_input;

  localparam int DEB = 4;
  localparam int WIN = 20;
  localparam int CW  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'h0;
  logic       prompt_valid = 1'b0;
  logic [1:0] prompt_dir = 2'b00;
  logic [1:0] dir_level;
  logic       resp_valid, resp_hit, resp_miss, resp_timeout, armed;

  simon_player_input #(
    .DEBOUNCE_CYCLES(DEB),
    .WINDOW_CYCLES  (WIN),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .prompt_valid(prompt_valid),
    .prompt_dir  (prompt_dir),
    .dir_level   (dir_level),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_miss   (resp_miss),
    .resp_timeout(resp_timeout),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [3:0] raw_hist[$];
  logic [3:0] m_deb, m_deb_prev;
  logic [1:0] m_dir, m_prompt;
  logic       m_await, m_rel, m_block;
  int         m_pedge, cyc;
  logic       e_valid, e_hit, e_miss, e_to;

  logic [6:0] obs, exp_vec;
  assign obs     = {dir_level, resp_valid, resp_hit, resp_miss, resp_timeout, armed};
  assign exp_vec = {m_dir, e_valid, e_hit, e_miss, e_to, m_await};

  function automatic logic [3:0] raw_at(input int i);
    if (i < 0) return 4'h0;
    return raw_hist[i];
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] v;
    logic       stable, press, answered;
    logic [1:0] code;
    if (rst) begin
      raw_hist.delete();
      m_deb = 4'h0; m_deb_prev = 4'h0; m_dir = 2'b00; m_prompt = 2'b00;
      m_await = 1'b0; m_rel = 1'b0; m_block = 1'b0; m_pedge = 0; cyc = 0;
      e_valid = 1'b0; e_hit = 1'b0; e_miss = 1'b0; e_to = 1'b0;
    end else begin
      press = |(m_deb & ~m_deb_prev);
      code  = 2'b00;
      for (int b = 0; b < 4; b++) if (m_deb[b]) code = 2'(b);
      e_valid = 1'b0; e_hit = 1'b0; e_miss = 1'b0; e_to = 1'b0;
      answered = 1'b0;
      if (m_await) begin
        if (m_block && m_deb == 4'h0) m_block = 1'b0;
        if (press && !m_block) begin
          answered = 1'b1;
          e_valid  = 1'b1;
          if ($countones(m_deb) == 1) begin
            m_dir  = code;
            e_hit  = (code == m_prompt);
            e_miss = !e_hit;
          end else begin
            e_miss = 1'b1;
          end
          m_await = 1'b0;
          m_rel   = 1'b1;
        end else if (prompt_valid || cyc == m_pedge + WIN) begin
          e_to    = 1'b1;
          m_await = 1'b0;
        end
      end else if (m_rel) begin
        if (m_deb == 4'h0) m_rel = 1'b0;
      end else if (press && $countones(m_deb) == 1) begin
        m_dir = code;
      end
      if (prompt_valid) begin
        m_await  = 1'b1;
        m_rel    = 1'b0;
        m_prompt = prompt_dir;
        m_pedge  = cyc;
        m_block  = (m_deb != 4'h0);
      end
      // Debounced value: the synchronised value seen over the last DEB cycles, if constant
      v = raw_at(cyc - 2);
      stable = 1'b1;
      for (int k = 1; k < DEB; k++) if (raw_at(cyc - 2 - k) !== v) stable = 1'b0;
      m_deb_prev = m_deb;
      if (stable && v != m_deb) m_deb = v;
      raw_hist.push_back(btn);
      cyc++;
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== 7'b0) $display("FAIL reset_state i=%0d got=%b want=%b", i, obs, 7'b0);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_hit_latency();
    int seen = -1;
    logic hit_seen = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL hit_model i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
      if (resp_valid && seen < 0) begin seen = i; hit_seen = resp_hit; end
      case (i)
        0: begin prompt_valid = 1'b1; prompt_dir = 2'b01; end
        1: prompt_valid = 1'b0;
        3: btn = 4'b0010;
        12: btn = 4'b0000;
        default: ;
      endcase
    end
    n_chk++;
    if (seen !== 3 + DEB + 3) $display("FAIL hit_latency got=%0d want=%0d", seen, 3 + DEB + 3);
    else n_pass++;
    n_chk++;
    if (hit_seen !== 1'b1) $display("FAIL hit_flag got=%b want=1", hit_seen);
    else n_pass++;
    n_chk++;
    if ({dir_level, armed} !== 3'b010) $display("FAIL hit_level got=%b want=010", {dir_level, armed});
    else n_pass++;
  endtask

  task automatic test_miss();
    int misses = 0, valids = 0;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL miss_model i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
      if (resp_valid) valids++;
      if (resp_miss) misses++;
      case (i)
        0, 20: begin prompt_valid = 1'b1; prompt_dir = 2'b10; end
        1, 21: prompt_valid = 1'b0;
        2: btn = 4'b1000;
        22: btn = 4'b0101;
        10, 30: btn = 4'b0000;
        default: ;
      endcase
    end
    n_chk++;
    if (misses !== 2 || valids !== 2) $display("FAIL miss_count got=%0d/%0d want=2/2", misses, valids);
    else n_pass++;
    n_chk++;
    if (dir_level !== 2'b11) $display("FAIL miss_level got=%b want=11", dir_level);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int valids = 0, seen = -1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL bounce_model i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
      if (resp_valid) begin valids++; if (seen < 0) seen = i; end
      case (i)
        0: begin prompt_valid = 1'b1; prompt_dir = 2'b00; end
        1: prompt_valid = 1'b0;
        2, 6, 10: btn = 4'b0001;
        4, 8, 25: btn = 4'b0000;
        default: ;
      endcase
    end
    n_chk++;
    if (valids !== 1 || seen !== 10 + DEB + 3)
      $display("FAIL bounce_once got=%0d@%0d want=1@%0d", valids, seen, 10 + DEB + 3);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int to_at = -1, valids = 0, hit_at = -1, touts = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL tout_model i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
      if (resp_timeout && to_at < 0) to_at = i;
      if (resp_valid) valids++;
      case (i)
        0: begin prompt_valid = 1'b1; prompt_dir = 2'b11; end
        1: prompt_valid = 1'b0;
        default: ;
      endcase
    end
    n_chk++;
    if (to_at !== 1 + WIN || valids !== 0 || armed !== 1'b0)
      $display("FAIL tout_cycle got=%0d v=%0d a=%b want=%0d v=0 a=0", to_at, valids, armed, 1 + WIN);
    else n_pass++;
    // Press whose result lands exactly on the expiry decision
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL edge_model i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
      if (resp_hit && hit_at < 0) hit_at = i;
      if (resp_timeout) touts++;
      case (i)
        0: begin prompt_valid = 1'b1; prompt_dir = 2'b11; end
        1: prompt_valid = 1'b0;
        14: btn = 4'b1000;
        24: btn = 4'b0000;
        default: ;
      endcase
    end
    n_chk++;
    if (hit_at !== 1 + WIN || touts !== 0)
      $display("FAIL press_wins got=%0d t=%0d want=%0d t=0", hit_at, touts, 1 + WIN);
    else n_pass++;
  endtask

  task automatic test_held();
    int to_at = -1, valids = 0, hit_at = -1;
    for (int i = 0; i < 75; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL held_model i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
      if (resp_timeout && to_at < 0) to_at = i;
      if (resp_valid) valids++;
      if (resp_hit && hit_at < 0) hit_at = i;
      case (i)
        0, 52: btn = 4'b0100;
        35, 62: btn = 4'b0000;
        10, 50: begin prompt_valid = 1'b1; prompt_dir = 2'b10; end
        11, 51: prompt_valid = 1'b0;
        default: ;
      endcase
    end
    n_chk++;
    if (to_at !== 11 + WIN || valids !== 1 || hit_at !== 52 + DEB + 3)
      $display("FAIL held_btn got=t%0d v%0d h%0d want=t%0d v1 h%0d", to_at, valids, hit_at, 11 + WIN, 52 + DEB + 3);
    else n_pass++;
  endtask

  task automatic test_reprompt_reset();
    int to_at = -1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL reprompt_model i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
      if (resp_timeout && to_at < 0) to_at = i;
      case (i)
        0: begin prompt_valid = 1'b1; prompt_dir = 2'b01; end
        5: begin prompt_valid = 1'b1; prompt_dir = 2'b10; end
        1, 6: prompt_valid = 1'b0;
        default: ;
      endcase
    end
    n_chk++;
    if (to_at !== 6 || armed !== 1'b1) $display("FAIL reprompt got=%0d a=%b want=6 a=1", to_at, armed);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if (obs !== 7'b0) $display("FAIL async_reset got=%b want=%b", obs, 7'b0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== 7'b0) $display("FAIL reset_hold i=%0d got=%b want=%b", i, obs, 7'b0);
      else n_pass++;
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL post_reset i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec) $display("FAIL random i=%0d got=%b want=%b", i, obs, exp_vec);
      else n_pass++;
      prompt_valid = ($urandom_range(0, 29) == 0);
      prompt_dir   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) btn = 4'b0001 << r;
        else if (r < 8) btn = 4'b0000;
        else if (r == 8) btn = 4'($urandom_range(0, 15));
      end
    end
    prompt_valid = 1'b0;
    btn = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_hit_latency();
    test_miss();
    test_bounce();
    test_timeout();
    test_held();
    test_reprompt_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
